// File: rtl/decode_pkg.sv
// Shared decode types and the pure immediate-extension function.
package decode_pkg;

   typedef enum logic [1:0] {
      IMM_I     = 2'b00,
      IMM_J     = 2'b01,
      IMM_RSV   = 2'b10,
      IMM_SHAMT = 2'b11
   } imm_src_e;

   localparam logic [31:0] IMM_DEFAULT = 32'h00FF_FFFF;

   function automatic logic [31:0] ext_imm(input logic [25:0] a, input logic [1:0] src);
      logic [31:0] r;
      case (src)
         IMM_I:     r = {{16{a[15]}}, a[15:0]};
         IMM_J:     r = {6'b0, a};
         IMM_SHAMT: r = {24'b0, a[10:3]};
         default:   r = IMM_DEFAULT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/extend_arbiter_rr_arb2.sv
// Two-input round-robin picker; pointer moves only when a grant is taken.
module rr_arb2
   import decode_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic last_grant;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      gnt_id = 1'b0;
      gnt    = 2'b00;
      if (req == 2'b11) gnt_id = ~last_grant;
      else              gnt_id = req[1];
      if (en && (|req)) gnt = gnt_id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              last_grant <= 1'b1;
      else if (en && (|req))   last_grant <= gnt_id;
   end

endmodule

// File: rtl/extend_arbiter.sv
// Shares one immediate-extension path between scalar and vector decode.
// Optional macro EXT_ILLEGAL_CHK_EN adds rsp_err and zeroes reserved-mode results.
module extend_arbiter
   import decode_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREQ = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0][25:0] req_imm,
   input  logic [NREQ-1:0][1:0]  req_immsrc,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [N-1:0]          rsp_ext
`ifdef EXT_ILLEGAL_CHK_EN
   ,
   output logic                  rsp_err
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e      state_q, state_d;
   logic        owner_q;
   logic        accept;
   logic        load;
   logic        gnt_id;
   logic [1:0]  gnt;
   logic [25:0] sel_imm;
   logic [1:0]  sel_src;
   logic [N-1:0] sel_ext;

   // rst_n gates accept so nothing is handshaken while reset is held.
   assign accept = rst_n && ((state_q == EMPTY) || rsp_ready[owner_q]);
   assign load   = accept && (|req_valid);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .en    (accept),
      .gnt   (gnt),
      .gnt_id(gnt_id)
   );

   assign req_ready = gnt;
   assign sel_imm   = req_imm[gnt_id];
   assign sel_src   = req_immsrc[gnt_id];
   assign sel_ext   = N'(ext_imm(sel_imm, sel_src));

   always_comb begin
      state_d = state_q;
      if (load)        state_d = FULL;
      else if (accept) state_d = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= 1'b0;
         rsp_ext <= '0;
      end else if (load) begin
         owner_q <= gnt_id;
`ifdef EXT_ILLEGAL_CHK_EN
         rsp_ext <= (sel_src == IMM_RSV) ? '0 : sel_ext;
`else
         rsp_ext <= sel_ext;
`endif
      end
   end

`ifdef EXT_ILLEGAL_CHK_EN
   logic err_seen;

   // err_seen is sticky until reset so a reserved mode is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err  <= 1'b0;
         err_seen <= 1'b0;
      end else if (load) begin
         rsp_err <= (sel_src == IMM_RSV);
         if (sel_src == IMM_RSV) err_seen <= 1'b1;
      end
   end
`endif

   always_comb begin
      rsp_valid = '0;
      if (state_q == FULL) rsp_valid[owner_q] = 1'b1;
   end

endmodule

// File: tb/tb_extend_arbiter.sv
// Directed table-driven bench for extend_arbiter plus reset and error sequences.
module tb_extend_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][25:0] req_imm;
   logic [1:0][1:0]  req_immsrc;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [31:0]      rsp_ext;
`ifdef EXT_ILLEGAL_CHK_EN
   logic             rsp_err;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   extend_arbiter #(.N(32), .NREQ(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_imm   (req_imm),
      .req_immsrc(req_immsrc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_ext   (rsp_ext)
`ifdef EXT_ILLEGAL_CHK_EN
      ,
      .rsp_err   (rsp_err)
`endif
   );

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  ready;
      logic [25:0] imm0;
      logic [1:0]  src0;
      logic [25:0] imm1;
      logic [1:0]  src1;
      logic [1:0]  exp_rr;
      logic [1:0]  exp_rv;
      logic [31:0] exp_ext;
      bit          chk_ext;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic [25:0] i0,
                        input logic [1:0] s0, input logic [25:0] i1, input logic [1:0] s1);
      req_valid     = v;
      rsp_ready     = r;
      req_imm[0]    = i0;
      req_immsrc[0] = s0;
      req_imm[1]    = i1;
      req_immsrc[1] = s1;
   endtask

   initial begin
      logic [31:0] rsv_exp;
`ifdef EXT_ILLEGAL_CHK_EN
      rsv_exp = 32'h0000_0000;
`else
      rsv_exp = 32'h00FF_FFFF;
`endif
      //             valid  ready imm0        src0   imm1        src1   rr     rv     ext           chk
      vecs[0]  = '{2'b01, 2'b01, 26'h0008001, 2'b00, 26'h00007F8, 2'b11, 2'b01, 2'b01, 32'hFFFF8001, 1'b1};
      vecs[1]  = '{2'b10, 2'b01, 26'h0008001, 2'b00, 26'h00007F8, 2'b11, 2'b10, 2'b10, 32'h000000FF, 1'b1};
      vecs[2]  = '{2'b11, 2'b10, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b01, 2'b01, 32'h03FFFFFF, 1'b1};
      vecs[3]  = '{2'b11, 2'b01, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b10, 2'b10, 32'h000000FF, 1'b1};
      vecs[4]  = '{2'b11, 2'b10, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b01, 2'b01, 32'h03FFFFFF, 1'b1};
      vecs[5]  = '{2'b11, 2'b01, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b10, 2'b10, 32'h000000FF, 1'b1};
      vecs[6]  = '{2'b11, 2'b00, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b00, 2'b10, 32'h000000FF, 1'b1};
      vecs[7]  = '{2'b11, 2'b00, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b00, 2'b10, 32'h000000FF, 1'b1};
      vecs[8]  = '{2'b11, 2'b01, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b00, 2'b10, 32'h000000FF, 1'b1};
      vecs[9]  = '{2'b11, 2'b10, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b01, 2'b01, 32'h03FFFFFF, 1'b1};
      vecs[10] = '{2'b00, 2'b01, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11, 2'b00, 2'b00, 32'h00000000, 1'b0};
      vecs[11] = '{2'b01, 2'b01, 26'h1234567, 2'b10, 26'h00007F8, 2'b11, 2'b01, 2'b01, rsv_exp,      1'b1};
      vecs[12] = '{2'b01, 2'b01, 26'h2AB7FFF, 2'b00, 26'h00007F8, 2'b11, 2'b01, 2'b01, 32'h00007FFF, 1'b1};
      vecs[13] = '{2'b00, 2'b01, 26'h2AB7FFF, 2'b00, 26'h00007F8, 2'b11, 2'b00, 2'b00, 32'h00000000, 1'b0};

      // Reset state, with requests already asserted.
      rst_n = 1'b0;
      drive(2'b11, 2'b11, 26'h0008001, 2'b00, 26'h00007F8, 2'b11);
      repeat (2) @(posedge clk);
      #2;
      check("reset req_ready", {30'b0, req_ready}, 32'h0);
      check("reset rsp_valid", {30'b0, rsp_valid}, 32'h0);
      check("reset rsp_ext", rsp_ext, 32'h0);
`ifdef EXT_ILLEGAL_CHK_EN
      check("reset rsp_err", {31'b0, rsp_err}, 32'h0);
`endif
      drive(2'b00, 2'b00, 26'h0, 2'b00, 26'h0, 2'b00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].valid, vecs[i].ready, vecs[i].imm0, vecs[i].src0, vecs[i].imm1, vecs[i].src1);
         #1;
         check($sformatf("v%0d req_ready", i), {30'b0, req_ready}, {30'b0, vecs[i].exp_rr});
         @(posedge clk);
         #1;
         check($sformatf("v%0d rsp_valid", i), {30'b0, rsp_valid}, {30'b0, vecs[i].exp_rv});
         if (vecs[i].chk_ext) check($sformatf("v%0d rsp_ext", i), rsp_ext, vecs[i].exp_ext);
`ifdef EXT_ILLEGAL_CHK_EN
         if (i == 11) begin
            check("rsv rsp_err", {31'b0, rsp_err}, 32'h1);
            check("rsv err_seen", {31'b0, dut.err_seen}, 32'h1);
         end
         if (i == 12) check("legal rsp_err", {31'b0, rsp_err}, 32'h0);
`endif
      end

      // Fill the register with the owner stalled, then reset mid-cycle.
      drive(2'b01, 2'b00, 26'h0008001, 2'b00, 26'h00007F8, 2'b11);
      @(posedge clk);
      #1;
      check("prereset rsp_valid", {30'b0, rsp_valid}, 32'h1);
      drive(2'b11, 2'b00, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11);
      #3;
      rst_n = 1'b0;
      #1;
      check("async rsp_valid", {30'b0, rsp_valid}, 32'h0);
      check("async rsp_ext", rsp_ext, 32'h0);
      check("async req_ready", {30'b0, req_ready}, 32'h0);
`ifdef EXT_ILLEGAL_CHK_EN
      check("async err_seen", {31'b0, dut.err_seen}, 32'h0);
`endif
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      drive(2'b11, 2'b11, 26'h3FFFFFF, 2'b01, 26'h00007F8, 2'b11);
      #1;
      check("post-reset tie req_ready", {30'b0, req_ready}, 32'h1);
      @(posedge clk);
      #1;
      check("post-reset rsp_valid", {30'b0, rsp_valid}, 32'h1);
      check("post-reset rsp_ext", rsp_ext, 32'h03FFFFFF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/extend_arbiter.md
Name: extend_arbiter

Overview:
- Shares one immediate-extension datapath between two decode requesters: requester 0 is scalar decode, requester 1 is vector decode.
- Each request is a 26-bit instruction field plus a 2-bit ImmSrc. The block returns an N-bit extended immediate to the requester that issued it.
- Round-robin arbitration, single-entry registered output, valid/ready handshakes on both sides.
- Sits in the decode stage, between the decode control logic and the ID/EX pipeline register.

Parameters:
N  32  width of the extended immediate
NREQ  2  number of requesters (fixed at 2 in this revision)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accepted this cycle
req_imm  in  NREQ x 26  instruction immediate field per requester
req_immsrc  in  NREQ x 2  extension mode per requester
rsp_valid  out  NREQ  result valid for requester i
rsp_ready  in  NREQ  requester i consumes result
rsp_ext  out  N  extended immediate, shared bus, qualified by rsp_valid
rsp_err  out  1  present only with EXT_ILLEGAL_CHK_EN

Behaviour:
- Extension rules, combinational on the granted request:
  - ImmSrc 00: sign-extend A[15:0] (16 copies of A[15]).
  - ImmSrc 01: zero-extend A[25:0].
  - ImmSrc 11: zero-extend A[10:3] (8 bits).
  - ImmSrc 10: undefined mode; result is 32'h00FF_FFFF.
- State machine, two states:
  - EMPTY: output register empty.
  - FULL: register holds a result; owner id is stored in the register.
- Accept condition: accept = EMPTY, or (FULL and rsp_ready[owner]).
  - accept=1 with at least one req_valid: grant one requester, load the register, set owner, go to/stay in FULL.
  - FULL, rsp_ready[owner]=1, no req_valid: go to EMPTY.
- req_ready[i] = accept and grant==i. This is combinational and at most one bit is high per cycle.
- Latency:
  - Request accepted in cycle T gives rsp_valid[owner] in cycle T+1.
  - Throughput is 1 result per cycle per block when the owner drains every cycle.
- Round-robin arbitration:
  - Pointer last_grant holds the last requester granted.
  - When both requesters are valid, grant the one that is not last_grant.
  - With a single valid requester, that requester always wins.
  - last_grant updates only on an actual grant.
  - Reset value of last_grant is 1, so requester 0 wins the first tie.
- rsp_valid is one-hot or zero; only rsp_valid[owner] can be high.
- rsp_ext holds its value while FULL and rsp_ready[owner]=0; it must not change until drained.
- rsp_ready from a non-owner requester is ignored.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY, rsp_valid=0, rsp_ext=0, owner=0, last_grant=1, rsp_err=0.
  - Any pending result is discarded, and req_ready=0 while rst_n=0.
- No starvation: a continuously valid requester is granted within 2 accept slots.

Optional Feature:
- Macro: EXT_ILLEGAL_CHK_EN.
- Defined:
  - rsp_err port exists; it is registered alongside rsp_ext and is 1 when the captured ImmSrc==10.
  - rsp_ext is forced to 0 for such entries.
  - A sticky internal flag err_seen (clear on reset only) is observable via hierarchy for the bench.
- Undefined:
  - No rsp_err port.
  - ImmSrc 10 yields 32'h00FF_FFFF with no flag.

Decomposition:
- Shared package (decode_pkg):
  - ImmSrc enum: IMM_I=2'b00, IMM_J=2'b01, IMM_RSV=2'b10, IMM_SHAMT=2'b11.
  - IMM_DEFAULT constant 32'h00FF_FFFF.
  - The pure extension function ext_imm(A, src).
- One sub-module: rr_arb2, a two-input round-robin picker with grant, enable and pointer update.
- The FSM and output register stay in extend_arbiter.

Test Plan:
- Req0 only, imm=26'h000_8001, src=00, rsp_ready=1 → req_ready[0] at T, rsp_valid[0] at T+1, rsp_ext=32'hFFFF_8001.
- Both valid every cycle:
  - Req0 src=01 imm=26'h3FF_FFFF; req1 src=11 imm=26'h000_07F8.
  - Expect grants 0,1,0,1.
  - rsp_ext alternates 32'h03FF_FFFF and 32'h0000_00FF.
- Backpressure: owner rsp_ready=0 for 3 cycles → req_ready=0 for both, rsp_ext stable. On release, the next grant occurs in the same cycle as the drain.
- src=10, imm=any:
  - Macro off → rsp_ext=32'h00FF_FFFF.
  - EXT_ILLEGAL_CHK_EN on → rsp_ext=0, rsp_err=1.
- Assert rst_n=0 while FULL with rsp_ready=0 → rsp_valid drops immediately (async). After release, the first tie is granted to requester 0.
- Non-owner rsp_ready=1 while owner stalls → no drain, no state change.
